// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and default width.
package div_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div64_sub_cla.sv
// N-bit subtractor a-b built as a + ~b + 1 on 4-bit carry-lookahead groups;
// o_borrow is set when b > a.
module sub_cla #(
    parameter int N = 65
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow
);

    localparam int NG = (N + 3) / 4;

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;

    assign w_g = i_a & ~i_b;
    assign w_p = i_a ^ ~i_b;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            localparam int LO = 4 * gi;
            localparam int NB = ((N - LO) < 4) ? (N - LO) : 4;

            logic          w_cin;
            logic          w_cout;
            logic [NB:0]   w_cc;

            if (gi == 0) begin : g_first
                assign w_cin = 1'b1;
            end else begin : g_rest
                assign w_cin = g_grp[gi-1].w_cout;
            end

            // Each carry is a flat generate/propagate expression from the group carry-in.
            always_comb begin
                logic v_g;
                logic v_p;
                w_cc    = '0;
                w_cc[0] = w_cin;
                for (int k = 1; k <= NB; k++) begin
                    v_g = w_g[LO+k-1];
                    v_p = w_p[LO+k-1];
                    for (int j = k - 2; j >= 0; j--) begin
                        v_g = v_g | (v_p & w_g[LO+j]);
                        v_p = v_p & w_p[LO+j];
                    end
                    w_cc[k] = v_g | (v_p & w_cin);
                end
            end

            assign w_cout            = w_cc[NB];
            assign o_diff[LO +: NB]  = w_p[LO +: NB] ^ w_cc[NB-1:0];
        end
    endgenerate

    assign o_borrow = ~g_grp[NG-1].w_cout;

endmodule

// File: rtl/seq_div64.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// The dividend register shifts out its MSB and collects quotient bits at the LSB.
module seq_div64
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_take;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};

    sub_cla #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a      (w_shift),
        .i_b      ({1'b0, r_dvs}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // The top difference bit can only be set together with a borrow.
    assign w_take = ~(w_borrow | w_diff[WIDTH]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (divisor != '0) ? CALC : FINISH;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_next_state = FINISH;
                end
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            CALC:    busy = 1'b1;
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvs <= divisor;
                        if (divisor != '0) begin
                            r_quo <= dividend;
                            r_rem <= '0;
                            r_cnt <= CW'(WIDTH - 1);
                            r_dbz <= 1'b0;
                        end else begin
                            r_quo <= '1;
                            r_rem <= dividend;
                            r_dbz <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_quo <= {r_quo[WIDTH-2:0], w_take};
                    r_rem <= w_take ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div64.sv
// Directed and small randomized check of seq_div64 against hand-computed results.
module tb_seq_div64;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_div64 #(.WIDTH(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one division; latency counts clock edges after the accepting edge
    // up to the edge at which done is sampled high (-1 on timeout).
    task automatic run(input logic [63:0] a, input logic [63:0] b, input int inject_at,
                       output int lat, output bit busy_seen);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        lat       = -1;
        busy_seen = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 1) begin
                dividend = ~a;
                divisor  = b ^ 64'h5a5a;
            end
            if (n == inject_at) begin
                start    = 1'b1;
                dividend = 64'd999;
                divisor  = 64'd4;
            end
            if (busy) busy_seen = 1'b1;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        $display("div %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d", a, b, quotient, remainder,
                 div_by_zero, lat);
    endtask

    initial begin
        int          lat;
        bit          bsy;
        int          done_cnt;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] q_hold;

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_q", quotient, 64'd0);
        check("rst_r", remainder, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        reset_n = 1'b1;

        run(64'd100, 64'd7, -1, lat, bsy);
        check("basic_lat", 64'(lat), 64'd65);
        check("basic_q", quotient, 64'd14);
        check("basic_r", remainder, 64'd2);
        check("basic_dbz", {63'd0, div_by_zero}, 64'd0);
        check("basic_busy", {63'd0, bsy}, 64'd1);
        q_hold = quotient;
        @(negedge clk);
        check("done_pulse", {63'd0, done}, 64'd0);
        check("q_hold", quotient, 64'd14);
        check("r_hold", remainder, 64'd2);

        run(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, -1, lat, bsy);
        check("max_by1_lat", 64'(lat), 64'd65);
        check("max_by1_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        check("max_by1_r", remainder, 64'd0);

        run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, -1, lat, bsy);
        check("max_bymax_q", quotient, 64'd1);
        check("max_bymax_r", remainder, 64'd0);

        run(64'h8000_0000_0000_0000, 64'd3, -1, lat, bsy);
        check("msb_by3_q", quotient, 64'h2AAA_AAAA_AAAA_AAAA);
        check("msb_by3_r", remainder, 64'd2);

        run(64'd5, 64'd0, -1, lat, bsy);
        check("dz_lat", 64'(lat), 64'd1);
        check("dz_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        check("dz_r", remainder, 64'd5);
        check("dz_flag", {63'd0, div_by_zero}, 64'd1);
        check("dz_busy", {63'd0, bsy}, 64'd0);
        @(negedge clk);
        check("dz_done_pulse", {63'd0, done}, 64'd0);
        check("dz_flag_hold", {63'd0, div_by_zero}, 64'd1);

        run(64'd3, 64'd10, 30, lat, bsy);
        check("small_lat", 64'(lat), 64'd65);
        check("small_q", quotient, 64'd0);
        check("small_r", remainder, 64'd3);
        check("small_dbz_clr", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        check("ignored_start_busy", {63'd0, busy}, 64'd0);

        @(negedge clk);
        start    = 1'b1;
        dividend = 64'd12345;
        divisor  = 64'd67;
        @(posedge clk);
        repeat (20) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_q", quotient, 64'd0);
        check("abort_r", remainder, 64'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        done_cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        $display("reset abort: done pulses after release=%0d", done_cnt);

        run(64'd1000, 64'd33, -1, lat, bsy);
        check("post_rst_lat", 64'(lat), 64'd65);
        check("post_rst_q", quotient, 64'd30);
        check("post_rst_r", remainder, 64'd10);

        for (int t = 0; t < 30; t++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (rb == 64'd0) rb = 64'd1;
            run(ra, rb, -1, lat, bsy);
            check("rand_lat", 64'(lat), 64'd65);
            check("rand_q", quotient, ra / rb);
            check("rand_r", remainder, ra % rb);
            check("rand_recon", quotient * rb + remainder, ra);
            check("rand_rlt", {63'd0, remainder < rb}, 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
